window_buffer_gen: RTL and testbench
====================================

WINDOW_BUFFER_GEN -- requirements
Module: window_buffer_gen

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 640, pixels per line (>= 3).
REQ-002 SHALL have parameter IMG_HEIGHT, default 480, lines per frame (>= 3).
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port pixel_in  input  8  unsigned grey pixel, raster order.
REQ-006 SHALL have port pixel_valid  input  1  pixel_in accepted this cycle when high.
REQ-007 SHALL have port frame_start  input  1  qualifies the accepted pixel as row 0, col 0.
REQ-008 SHALL have port window_buffer  output  9x8 (unpacked [0:8])  3x3 window, row-major; [0] top-left, [2] top-right, [4] centre, [8] bottom-right.
REQ-009 SHALL have port start_calculations  output  1  one-cycle strobe: window_buffer holds a complete, valid window.
REQ-010 SHALL have port frame_done  output  1  one-cycle strobe after last pixel of a frame.

Function
REQ-011 SHALL keep col counter (0..IMG_WIDTH-1) and row counter (0..IMG_HEIGHT-1); col wraps to 0 and row increments on each accepted pixel at col IMG_WIDTH-1.
REQ-012 SHALL hold two line buffers of IMG_WIDTH x 8 bits, read-before-write at index col: bottom line = pixel_in, middle = line buffer 1 old value, top = line buffer 0 old value.
REQ-013 SHALL shift the 3x3 window one column left per accepted pixel, new column entering at [2],[5],[8] as top, middle, bottom.
REQ-014 SHALL leave window, counters and line buffers unchanged in cycles with pixel_valid low.
REQ-015 SHALL implement FSM IDLE -> FILL -> ACTIVE -> DONE -> IDLE.
REQ-016 IDLE: ignore pixels; go to FILL on pixel_valid & frame_start, that pixel stored as row 0, col 0.
REQ-017 FILL (rows 0-1): no start_calculations; go to ACTIVE when row 2, col 0 pixel accepted.
REQ-018 ACTIVE: assert start_calculations the cycle after accepting a pixel with row >= 2 and col >= 2 (registered, latency 1); never for col < 2 (no window across line wrap).
REQ-019 Accepting pixel (IMG_HEIGHT-1, IMG_WIDTH-1) SHALL move FSM to DONE; DONE asserts frame_done for exactly one cycle, coinciding with the final start_calculations, then IDLE.
REQ-020 pixel_valid & frame_start in FILL or ACTIVE SHALL abort the frame: counters restart at that pixel as (0,0), FSM to FILL, no frame_done.
REQ-021 Per complete frame, exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) start_calculations strobes SHALL occur.
REQ-022 window_buffer SHALL remain stable until the next accepted pixel.

Reset
REQ-023 n_rst low SHALL immediately force FSM IDLE, counters 0, window_buffer all 0x00, start_calculations 0, frame_done 0.
REQ-024 Line buffer contents need not reset; they SHALL never reach window_buffer during a strobe before being rewritten by the current frame.
REQ-025 Reset mid-frame SHALL discard the frame; next frame needs frame_start.

Configuration
REQ-026 Macro WINDOW_POS_EN defined: SHALL add outputs win_col and win_row, each 16 bits, registered with start_calculations, giving centre pixel coordinates (col-1, row-1); reset 0.
REQ-027 Macro WINDOW_POS_EN undefined: those ports and registers SHALL be absent; all else identical.

Verification (IMG_WIDTH=4, IMG_HEIGHT=4, pixel = row*16+col)
REQ-028 Full frame, pixel_valid constant high -> exactly 4 start_calculations; first window_buffer = 00,01,02,10,11,12,20,21,22; frame_done coincides with 4th strobe.
REQ-029 Same frame with pixel_valid low every other cycle -> identical 4 windows in same order; no strobe in gap cycles.
REQ-030 pixel_valid high, frame_start never asserted -> no strobe, no frame_done, window_buffer stays 0x00.
REQ-031 frame_start re-asserted at pixel (2,1), then full frame -> no frame_done for aborted frame; next windows match REQ-028.
REQ-032 n_rst low during row 3 -> outputs 0 asynchronously; subsequent full frame matches REQ-028.
REQ-033 With WINDOW_POS_EN -> strobes report (win_col,win_row) = (1,1),(2,1),(1,2),(2,2).

Source files
------------

// File: rtl/window_buffer_gen.sv
// Streaming 3x3 sliding-window generator over a raster-order 8-bit image, built on two line buffers.
// Optional macro WINDOW_POS_EN adds win_col/win_row centre-coordinate outputs.
module window_buffer_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] pixel_in,
  input  logic       pixel_valid,
  input  logic       frame_start,
  output logic [7:0] window_buffer [0:8],
  output logic       start_calculations,
  output logic       frame_done
`ifdef WINDOW_POS_EN
  ,
  output logic [15:0] win_col,
  output logic [15:0] win_row
`endif
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, ACTIVE = 2'd2, DONE = 2'd3} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [7:0]    win_q [0:8];
  logic          start_q, done_q;
  logic [7:0]    lb0_q [0:IMG_WIDTH-1];
  logic [7:0]    lb1_q [0:IMG_WIDTH-1];

  logic          restart_s, in_frame_s, accept_s, last_s, strobe_s;
  logic [CW-1:0] eff_col_s;
  logic [RW-1:0] eff_row_s;
  logic [7:0]    top_s, mid_s;

  // A frame_start pixel is always taken as (0,0), which also aborts a frame in flight.
  assign restart_s  = pixel_valid & frame_start;
  assign in_frame_s = (state_q == FILL) || (state_q == ACTIVE);
  assign accept_s   = restart_s | (pixel_valid & in_frame_s);
  assign eff_col_s  = restart_s ? '0 : col_q;
  assign eff_row_s  = restart_s ? '0 : row_q;
  assign last_s     = accept_s & (eff_col_s == COL_LAST) & (eff_row_s == ROW_LAST);
  assign strobe_s   = accept_s & (eff_col_s >= COL_TWO) & (eff_row_s >= ROW_TWO);
  assign top_s      = lb0_q[eff_col_s];
  assign mid_s      = lb1_q[eff_col_s];

  // Next-state and raster counter logic.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    case (state_q)
      IDLE:    if (restart_s) state_d = FILL; else state_d = IDLE;
      FILL:    if (restart_s) state_d = FILL;
               else if (accept_s && eff_row_s == ROW_TWO && eff_col_s == '0) state_d = ACTIVE;
               else state_d = FILL;
      ACTIVE:  if (restart_s) state_d = FILL;
               else if (last_s) state_d = DONE;
               else state_d = ACTIVE;
      DONE:    if (restart_s) state_d = FILL; else state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept_s) begin
      if (eff_col_s == COL_LAST) begin
        col_d = '0;
        row_d = (eff_row_s == ROW_LAST) ? '0 : eff_row_s + ROW_ONE;
      end else begin
        col_d = eff_col_s + COL_ONE;
        row_d = eff_row_s;
      end
    end else begin
      col_d = col_q;
      row_d = row_q;
    end
  end

  // Control state, counters, strobes and the window shift register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < 9; i++) win_q[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      start_q <= strobe_s;
      done_q  <= last_s;
      if (accept_s) begin
        win_q[0] <= win_q[1];
        win_q[1] <= win_q[2];
        win_q[2] <= top_s;
        win_q[3] <= win_q[4];
        win_q[4] <= win_q[5];
        win_q[5] <= mid_s;
        win_q[6] <= win_q[7];
        win_q[7] <= win_q[8];
        win_q[8] <= pixel_in;
      end
    end
  end

  // Line buffers: read-before-write, each column moves up one line per accepted pixel.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      lb0_q[eff_col_s] <= lb1_q[eff_col_s];
      lb1_q[eff_col_s] <= pixel_in;
    end
  end

`ifdef WINDOW_POS_EN
  logic [15:0] win_col_q, win_row_q;

  // Centre coordinates are one column and one row behind the newest pixel.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      win_col_q <= 16'd0;
      win_row_q <= 16'd0;
    end else if (strobe_s) begin
      win_col_q <= 16'(eff_col_s) - 16'd1;
      win_row_q <= 16'(eff_row_s) - 16'd1;
    end
  end

  assign win_col = win_col_q;
  assign win_row = win_row_q;
`endif

  assign window_buffer      = win_q;
  assign start_calculations = start_q;
  assign frame_done         = done_q;

endmodule

// File: tb/tb_window_buffer_gen.sv
// Randomised self-checking bench for window_buffer_gen on a 4x4 image against a frame-array reference model.
module tb_window_buffer_gen;

  localparam int W = 4;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [7:0] pixel_in;
  logic       pixel_valid;
  logic       frame_start;
  logic [7:0] window_buffer [0:8];
  logic       start_calculations;
  logic       frame_done;
  logic [71:0] win_flat;
`ifdef WINDOW_POS_EN
  logic [15:0] win_col, win_row;
`endif

  window_buffer_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .n_rst(n_rst), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
    .frame_start(frame_start), .window_buffer(window_buffer),
    .start_calculations(start_calculations), .frame_done(frame_done)
`ifdef WINDOW_POS_EN
    , .win_col(win_col), .win_row(win_row)
`endif
  );

  always #5 clk = ~clk;

  assign win_flat = {window_buffer[0], window_buffer[1], window_buffer[2],
                     window_buffer[3], window_buffer[4], window_buffer[5],
                     window_buffer[6], window_buffer[7], window_buffer[8]};

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: the frame as a 2-D array, position derived from the pixel index since frame_start.
  logic [7:0]  img [0:H-1][0:W-1];
  bit          m_act;
  int          m_k;
  bit          exp_strobe, exp_done, win_known;
  logic [71:0] exp_win;
  int          exp_col, exp_row;

  function automatic logic [7:0] pat(input int k);
    return 8'((k / W) * 16 + (k % W));
  endfunction

  task automatic model_reset();
    m_act = 1'b0; m_k = 0; exp_strobe = 1'b0; exp_done = 1'b0;
    win_known = 1'b1; exp_win = 72'h0;
  endtask

  task automatic step(input bit v, input bit fs, input logic [7:0] pix);
    int r, c;
    pixel_valid = v; frame_start = fs; pixel_in = pix;
    @(posedge clk);
    exp_strobe = 1'b0;
    exp_done   = 1'b0;
    if (v && fs) begin
      m_act = 1'b1;
      m_k   = 0;
    end
    if (v && m_act) begin
      r = m_k / W;
      c = m_k % W;
      img[r][c]  = pix;
      exp_strobe = (r >= 2) && (c >= 2);
      exp_done   = (m_k == W * H - 1);
      if (exp_strobe) begin
        for (int i = 0; i < 9; i++) exp_win[71 - 8*i -: 8] = img[r - 2 + i/3][c - 2 + i%3];
        exp_col = c - 1;
        exp_row = r - 1;
      end
      win_known = exp_strobe;
      m_k++;
      if (exp_done) m_act = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; pixel_valid = 1'b0; frame_start = 1'b0; pixel_in = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (start_calculations !== 1'b0) begin n_bad++; $display("FAIL reset_strobe got %b want 0", start_calculations); end
    n_vec++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", frame_done); end
    n_vec++; if (win_flat !== 72'h0) begin n_bad++; $display("FAIL reset_window got %h want 0", win_flat); end
    n_rst = 1'b1;
  endtask

  task automatic test_full_frame(input string tag, input bit gap);
    int n_str = 0, n_done = 0;
    logic [71:0] first_win = 72'h0;
    for (int k = 0; k < W * H + (gap ? W * H : 0) + 2; k++) begin
      if (k >= (gap ? 2 * W * H : W * H)) step(1'b0, 1'b0, 8'($urandom));
      else if (gap && (k % 2 == 1)) step(1'b0, 1'b0, 8'($urandom));
      else step(1'b1, k == 0, pat(gap ? k / 2 : k));
      n_vec++; if (start_calculations !== exp_strobe) begin n_bad++; $display("FAIL %s_strobe k=%0d got %b want %b", tag, k, start_calculations, exp_strobe); end
      n_vec++; if (frame_done !== exp_done) begin n_bad++; $display("FAIL %s_done k=%0d got %b want %b", tag, k, frame_done, exp_done); end
      if (win_known) begin
        n_vec++; if (win_flat !== exp_win) begin n_bad++; $display("FAIL %s_window k=%0d got %h want %h", tag, k, win_flat, exp_win); end
      end
`ifdef WINDOW_POS_EN
      if (exp_strobe) begin
        n_vec++; if (win_col !== 16'(exp_col) || win_row !== 16'(exp_row)) begin n_bad++; $display("FAIL %s_pos got (%0d,%0d) want (%0d,%0d)", tag, win_col, win_row, exp_col, exp_row); end
      end
`endif
      if (start_calculations === 1'b1) begin
        if (n_str == 0) first_win = win_flat;
        n_str++;
      end
      if (frame_done === 1'b1) n_done++;
    end
    n_vec++; if (n_str != 4) begin n_bad++; $display("FAIL %s_strobe_count got %0d want 4", tag, n_str); end
    n_vec++; if (n_done != 1) begin n_bad++; $display("FAIL %s_done_count got %0d want 1", tag, n_done); end
    n_vec++; if (first_win !== 72'h000102101112202122) begin n_bad++; $display("FAIL %s_first_window got %h want 000102101112202122", tag, first_win); end
  endtask

  task automatic test_no_frame_start();
    n_rst = 1'b0; #2; model_reset(); n_rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b0, 8'($urandom_range(1, 255)));
      n_vec++; if (start_calculations !== 1'b0 || frame_done !== 1'b0) begin n_bad++; $display("FAIL nofs_strobes k=%0d got %b%b want 00", k, start_calculations, frame_done); end
      n_vec++; if (win_flat !== 72'h0) begin n_bad++; $display("FAIL nofs_window k=%0d got %h want 0", k, win_flat); end
    end
  endtask

  task automatic test_abort();
    for (int k = 0; k <= 8; k++) begin
      step(1'b1, k == 0, pat(k));
      n_vec++; if (start_calculations !== exp_strobe || frame_done !== 1'b0) begin n_bad++; $display("FAIL abort_prefix k=%0d got %b%b want %b0", k, start_calculations, frame_done, exp_strobe); end
    end
    test_full_frame("abort", 1'b0);
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k <= 13; k++) step(1'b1, k == 0, pat(k));
    #2 n_rst = 1'b0;
    #1;
    model_reset();
    n_vec++; if (win_flat !== 72'h0) begin n_bad++; $display("FAIL midrst_window got %h want 0", win_flat); end
    n_vec++; if (start_calculations !== 1'b0 || frame_done !== 1'b0) begin n_bad++; $display("FAIL midrst_strobes got %b%b want 00", start_calculations, frame_done); end
    step(1'b1, 1'b0, 8'h55);
    n_rst = 1'b1;
    step(1'b1, 1'b0, 8'h66);
    n_vec++; if (start_calculations !== 1'b0 || win_flat !== 72'h0) begin n_bad++; $display("FAIL midrst_discard got %b/%h want 0/0", start_calculations, win_flat); end
    test_full_frame("midrst", 1'b0);
  endtask

  task automatic test_random();
    int n_str;
    for (int f = 0; f < 4; f++) begin
      bit started = 1'b0;
      n_str = 0;
      for (int cyc = 0; cyc < 200 && !(started && !m_act); cyc++) begin
        bit v = ($urandom_range(0, 9) < 7);
        bit fs = v && !started;
        step(v, fs, 8'($urandom));
        if (fs) started = 1'b1;
        n_vec++; if (start_calculations !== exp_strobe) begin n_bad++; $display("FAIL rand_strobe f=%0d got %b want %b", f, start_calculations, exp_strobe); end
        n_vec++; if (frame_done !== exp_done) begin n_bad++; $display("FAIL rand_done f=%0d got %b want %b", f, frame_done, exp_done); end
        if (win_known) begin
          n_vec++; if (win_flat !== exp_win) begin n_bad++; $display("FAIL rand_window f=%0d got %h want %h", f, win_flat, exp_win); end
        end
        if (start_calculations === 1'b1) n_str++;
      end
      n_vec++; if (n_str != (W - 2) * (H - 2)) begin n_bad++; $display("FAIL rand_strobe_count f=%0d got %0d want %0d", f, n_str, (W - 2) * (H - 2)); end
      step(1'b0, 1'b0, 8'h00);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame("full", 1'b0);
    test_full_frame("gap", 1'b1);
    test_no_frame_start();
    test_abort();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
